ram_streamer: RTL

RAM_STREAMER -- requirements
Module: ram_streamer

---
 rtl/ram_streamer_pkg.sv | 12 +
 rtl/stream_skid_buffer.sv | 47 ++++
 rtl/ram_streamer.sv | 114 +++++++++++
 3 files changed

// File: rtl/ram_streamer_pkg.sv
// Shared definitions for the RAM burst streamer: FSM encodings and skid-buffer depth.
package ram_streamer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO holding RAM words between the read port and the downstream handshake.
module stream_skid_buffer
  import ram_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign full     = (count == 2'(FIFO_DEPTH));
  assign empty    = (count == 2'd0);
  assign do_pop   = pop && !empty;
  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/ram_streamer.sv
// Burst reader: streams Length words from a synchronous RAM read port onto a valid/ready interface.
//   state    | meaning
//   ST_IDLE  | waiting for Start_i; zero-length start only pulses Done_o
//   ST_READ  | issuing reads while buffered + in-flight words leave room
//   ST_DRAIN | all reads issued; waiting for the last word to transfer
module ram_streamer
  import ram_streamer_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic [ADDRESS_WIDTH-1:0] StartAddress_i,
  input  logic [ADDRESS_WIDTH:0]   Length_i,
  output logic                     RamReadEnable_o,
  output logic [ADDRESS_WIDTH-1:0] RamAddress_o,
  input  logic [DATA_WIDTH-1:0]    RamData_i,
  output logic [DATA_WIDTH-1:0]    Data_o,
  output logic                     Valid_o,
  input  logic                     Ready_i,
  output logic                     Busy_o,
  output logic                     Done_o
);

  localparam logic [ADDRESS_WIDTH:0] LEN_ONE = (ADDRESS_WIDTH+1)'(1);

  state_t                   state;
  state_t                   state_nxt;
  logic                     done_nxt;
  logic                     issue;
  logic                     pop;
  logic                     inflight;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [1:0]               buffered;
  logic [2:0]               occupancy;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [ADDRESS_WIDTH:0]   issue_left;
  logic [ADDRESS_WIDTH:0]   xfer_left;

  stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (Clock),
    .rst       (Reset),
    .push      (inflight),
    .push_data (RamData_i),
    .pop       (pop),
    .pop_data  (Data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign Valid_o         = !fifo_empty;
  assign pop             = Valid_o && Ready_i;
  assign buffered        = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  assign occupancy       = {1'b0, buffered} + {2'b00, inflight};
  assign RamReadEnable_o = issue;
  assign RamAddress_o    = addr;
  assign Busy_o          = (state != ST_IDLE);

  // A word popped this cycle frees its slot in time for a read issued now.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start_i) begin
          if (Length_i == '0) done_nxt = 1'b1;
          else                state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        issue = (issue_left != '0) && (occupancy < (3'd2 + {2'b00, pop}));
        if (issue && (issue_left == LEN_ONE)) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && (xfer_left == LEN_ONE)) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= ST_IDLE;
      Done_o     <= 1'b0;
      inflight   <= 1'b0;
      addr       <= '0;
      issue_left <= '0;
      xfer_left  <= '0;
    end else begin
      state    <= state_nxt;
      Done_o   <= done_nxt;
      inflight <= issue;
      if ((state == ST_IDLE) && Start_i && (Length_i != '0)) begin
        addr       <= StartAddress_i;
        issue_left <= Length_i;
        xfer_left  <= Length_i;
      end else begin
        if (issue) begin
          addr       <= addr + ADDRESS_WIDTH'(1);
          issue_left <= issue_left - LEN_ONE;
        end
        if (pop) xfer_left <= xfer_left - LEN_ONE;
      end
    end
  end

endmodule
